shader_program_store: RTL

- Double-buffered, parametrised instruction store for the tiny shader core; next generation of the single circular shift-register program memory.
- One bank executes, with random-access read at the program counter and a programmable program length. The other bank is filled through a valid/ready stream.
- A committed program swaps in only at the end of a program pass, so a frame never runs a half-loaded program.

---
 rtl/shader_pkg.sv | 40 ++++
 rtl/shader_program_bank.sv | 39 +++
 rtl/shader_program_store.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shader_pkg.sv
// Shared definitions for the shader program store.
//   - 8-bit encodings of the default boot program and the NOP filler
//   - instruction field layout typedef
//   - DEFAULT_PROG_LEN and default_word(), which yields the reset image word
//     for any bank address (program words first, NOP everywhere after).
package shader_pkg;

   localparam int DEFAULT_PROG_LEN = 6;

   // Default boot program: combine screen position with time into a colour.
   localparam logic [7:0] OP_GETX_R0    = 8'h10;
   localparam logic [7:0] OP_GETY_R1    = 8'h15;
   localparam logic [7:0] OP_XOR_R0_R1  = 8'h74;
   localparam logic [7:0] OP_GETTIME_R2 = 8'h1A;
   localparam logic [7:0] OP_ADD_R0_R2  = 8'h98;
   localparam logic [7:0] OP_SETRGB_R0  = 8'h00;
   localparam logic [7:0] OP_NOP        = 8'h40;

   // Field view of an 8-bit instruction word: opcode nibble, two register slots.
   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] ra;
      logic [1:0] rb;
   } instr_fields_t;

   function automatic logic [7:0] default_word(input int idx);
      logic [7:0] w;
      case (idx)
         0:       w = OP_GETX_R0;
         1:       w = OP_GETY_R1;
         2:       w = OP_XOR_R0_R1;
         3:       w = OP_GETTIME_R2;
         4:       w = OP_ADD_R0_R2;
         5:       w = OP_SETRGB_R0;
         default: w = OP_NOP;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/shader_program_bank.sv
// One NUM_INSTR x INSTR_WIDTH instruction bank.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (loads the default program)
//   we_i           write enable
//   waddr_i        write address
//   wdata_i        write data
//   raddr_i        read address
//   rdata_o        asynchronous read data, mem[raddr_i]
module shader_program_bank
   import shader_pkg::*;
#(
   parameter int INSTR_WIDTH = 8,
   parameter int NUM_INSTR   = 16,
   parameter int PTR_W       = $clog2(NUM_INSTR)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   we_i,
   input  logic [PTR_W-1:0]       waddr_i,
   input  logic [INSTR_WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0]       raddr_i,
   output logic [INSTR_WIDTH-1:0] rdata_o
);

   logic [INSTR_WIDTH-1:0] mem [NUM_INSTR];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_INSTR; i++) begin
            mem[i] <= INSTR_WIDTH'(default_word(i));
         end
      end else if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/shader_program_store.sv
// Double-buffered instruction store for the shader core.
// One bank executes (read at pc), the other (shadow) is filled from a
// valid/ready stream. A committed shadow program becomes active only when the
// running program wraps, so a pass never sees a half-loaded program.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   next_i                  advance pc (wraps at active_len-1)
//   instr_o, pc_o, last_o   active[pc], pc, pc == active_len-1
//   wr_valid_i, wr_data_i,  load stream into the shadow bank
//   wr_ready_o
//   commit_i, abort_i       arm the shadow program for swap / discard the load
//   pending_o, bank_o       swap armed, index of the active bank
//   commit_err_o            one-cycle pulse when a commit is rejected
// Handshake: a word transfers on a rising clk_i edge where wr_valid_i and
// wr_ready_o are both high; wr_ready_o does not depend on wr_valid_i, and a
// producer holds wr_data_i stable while wr_valid_i is high and ready is low.
module shader_program_store
   import shader_pkg::*;
#(
   parameter int INSTR_WIDTH = 8,
   parameter int NUM_INSTR   = 16,
   parameter int NUM_BANKS   = 2,
   parameter int PTR_W       = $clog2(NUM_INSTR)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   next_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [PTR_W-1:0]       pc_o,
   output logic                   last_o,
   input  logic                   wr_valid_i,
   input  logic [INSTR_WIDTH-1:0] wr_data_i,
   output logic                   wr_ready_o,
   input  logic                   commit_i,
   input  logic                   abort_i,
   output logic                   pending_o,
   output logic                   bank_o,
   output logic                   commit_err_o
);

   if (NUM_BANKS != 2) begin : g_bad_banks
      $error("shader_program_store: NUM_BANKS must be 2");
   end
   if (NUM_INSTR < 8 || (NUM_INSTR & (NUM_INSTR - 1)) != 0) begin : g_bad_depth
      $error("shader_program_store: NUM_INSTR must be a power of two >= 8");
   end
   if (PTR_W != $clog2(NUM_INSTR)) begin : g_bad_ptr
      $error("shader_program_store: PTR_W must equal clog2(NUM_INSTR)");
   end

   // Lengths and the write pointer must reach NUM_INSTR itself.
   localparam int LEN_W = PTR_W + 1;

   logic [PTR_W-1:0]       pc;
   logic [LEN_W-1:0]       wptr;
   logic [LEN_W-1:0]       active_len;
   logic [LEN_W-1:0]       shadow_len;
   logic                   pending;
   logic                   bank;
   logic                   commit_err;

   logic                   accept;
   logic                   last;
   logic                   swap;
   logic [LEN_W-1:0]       count_eff;
   logic                   commit_ok;
   logic                   commit_rej;
   logic                   we0;
   logic                   we1;
   logic [INSTR_WIDTH-1:0] rdata0;
   logic [INSTR_WIDTH-1:0] rdata1;

   assign wr_ready_o = !pending && (wptr < LEN_W'(NUM_INSTR));
   assign accept     = wr_valid_i && wr_ready_o;
   assign last       = ({1'b0, pc} == (active_len - LEN_W'(1)));
   assign swap       = pending && next_i && last;

   // A word accepted in the commit cycle belongs to the committed program.
   assign count_eff  = wptr + LEN_W'(accept);
   // Abort takes precedence: a commit alongside it is dropped without error.
   assign commit_ok  = commit_i && !abort_i && !pending && (count_eff != '0);
   assign commit_rej = commit_i && !abort_i && !commit_ok;

   // Writes go to the shadow bank only; an abort kills a same-cycle write.
   assign we0 = accept && !abort_i && bank;
   assign we1 = accept && !abort_i && !bank;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc         <= '0;
         wptr       <= '0;
         active_len <= LEN_W'(NUM_INSTR);
         shadow_len <= LEN_W'(NUM_INSTR);
         pending    <= 1'b0;
         bank       <= 1'b0;
         commit_err <= 1'b0;
      end else begin
         commit_err <= commit_rej;
         if (swap) begin
            // Swap clears pending/wptr itself, so it dominates a same-cycle abort.
            bank       <= ~bank;
            active_len <= shadow_len;
            pc         <= '0;
            wptr       <= '0;
            pending    <= 1'b0;
         end else begin
            if (next_i) begin
               pc <= last ? '0 : pc + PTR_W'(1);
            end
            if (abort_i) begin
               wptr    <= '0;
               pending <= 1'b0;
            end else begin
               if (accept) begin
                  wptr <= wptr + LEN_W'(1);
               end
               if (commit_ok) begin
                  pending    <= 1'b1;
                  shadow_len <= count_eff;
               end
            end
         end
      end
   end

   shader_program_bank #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .NUM_INSTR   (NUM_INSTR),
      .PTR_W       (PTR_W)
   ) u_bank0 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we0),
      .waddr_i (wptr[PTR_W-1:0]),
      .wdata_i (wr_data_i),
      .raddr_i (pc),
      .rdata_o (rdata0)
   );

   shader_program_bank #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .NUM_INSTR   (NUM_INSTR),
      .PTR_W       (PTR_W)
   ) u_bank1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we1),
      .waddr_i (wptr[PTR_W-1:0]),
      .wdata_i (wr_data_i),
      .raddr_i (pc),
      .rdata_o (rdata1)
   );

   assign instr_o      = bank ? rdata1 : rdata0;
   assign pc_o         = pc;
   assign last_o       = last;
   assign pending_o    = pending;
   assign bank_o       = bank;
   assign commit_err_o = commit_err;

endmodule
